// File: rtl/decode_stage_if.sv
// Fetch, write-back and execute signals seen by the decode stage.
// The slave modport is the decode stage's side of the bundle.
interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
);
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_data1;
    logic [DATA_W-1:0] ex_data2;
    logic [DATA_W-1:0] ex_imm;
    logic [AW-1:0]     ex_dest;
    logic [8:0]        ex_ctrl;

    modport slave (
        input  if_valid, if_instr, wb_en, wb_addr, wb_data, ex_ready,
        output if_ready, ex_valid, ex_data1, ex_data2, ex_imm,
        output ex_dest, ex_ctrl
    );

    modport master (
        output if_valid, if_instr, wb_en, wb_addr, wb_data, ex_ready,
        input  if_ready, ex_valid, ex_data1, ex_data2, ex_imm,
        input  ex_dest, ex_ctrl
    );
endinterface

// File: rtl/decode_stage.sv
// Pipelined decode: register file with write-back bypass, control decode,
// immediate extension, load-use scoreboard and valid/ready handshakes.
module decode_stage #(
    parameter int         DATA_W   = 32,
    parameter int         NREGS    = 32,
    parameter int         ZERO_REG = 1,
    parameter int         LOAD_LAT = 2,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LOAD  = 6'b100011,
    parameter logic [5:0] OP_STORE = 6'b011101,
    parameter logic [5:0] OP_BEQ   = 6'b100000,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_ANDI  = 6'b001100,
    parameter logic [5:0] OP_ORI   = 6'b001101
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [DATA_W-1:0] rf [NREGS];

    logic [5:0]        op;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     rd;
    logic [8:0]        ctrl;
    logic [AW-1:0]     dest;
    logic              use_rs;
    logic              use_rt;
    logic              zext;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;

    logic              rs_zero;
    logic              rt_zero;
    logic              wb_ok;
    logic              hazard;
    logic              ready;
    logic              accept;
    logic              leave;

    logic              pend;
    logic [AW-1:0]     pend_addr;
    logic [3:0]        pend_cnt;

    logic              ex_valid_q;
    logic [DATA_W-1:0] ex_data1_q;
    logic [DATA_W-1:0] ex_data2_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [AW-1:0]     ex_dest_q;
    logic [8:0]        ex_ctrl_q;

    assign op = bus.if_instr[31:26];
    assign rs = bus.if_instr[21 +: AW];
    assign rt = bus.if_instr[16 +: AW];
    assign rd = bus.if_instr[11 +: AW];

    // Opcode to {reg_write,mem_read,mem_write,mem_to_reg,alu_src,
    // branch,reg_dst,alu_op}, destination and operand usage.
    always_comb begin
        ctrl   = '0;
        dest   = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        zext   = 1'b0;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                ctrl   = 9'b1_0_0_0_0_0_1_10;
                dest   = rd;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            (op == OP_LOAD): begin
                ctrl   = 9'b1_1_0_1_1_0_0_00;
                dest   = rt;
                use_rs = 1'b1;
            end
            (op == OP_STORE): begin
                ctrl   = 9'b0_0_1_0_1_0_0_00;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            (op == OP_BEQ): begin
                ctrl   = 9'b0_0_0_0_0_1_0_01;
                use_rs = 1'b1;
                use_rt = 1'b1;
            end
            (op == OP_ADDI): begin
                ctrl   = 9'b1_0_0_0_1_0_0_11;
                dest   = rt;
                use_rs = 1'b1;
            end
            (op == OP_ANDI), (op == OP_ORI): begin
                ctrl   = 9'b1_0_0_0_1_0_0_11;
                dest   = rt;
                use_rs = 1'b1;
                zext   = 1'b1;
            end
            default: ;
        endcase
    end

    assign imm = zext
        ? {{(DATA_W-16){1'b0}}, bus.if_instr[15:0]}
        : {{(DATA_W-16){bus.if_instr[15]}}, bus.if_instr[15:0]};

    assign rs_zero = (ZERO_REG != 0) && (rs == '0);
    assign rt_zero = (ZERO_REG != 0) && (rt == '0);
    assign wb_ok   = bus.wb_en
                   && !((ZERO_REG != 0) && (bus.wb_addr == '0));

    assign data1 = (wb_ok && bus.wb_addr == rs) ? bus.wb_data
                 : (rs_zero ? '0 : rf[rs]);
    assign data2 = (wb_ok && bus.wb_addr == rt) ? bus.wb_data
                 : (rt_zero ? '0 : rf[rt]);

    // A source clashes with the load in the output register or the
    // pending load; a second load waits until the scoreboard is free.
    always_comb begin
        hazard = 1'b0;
        if (use_rs && rs != '0) begin
            if (ex_valid_q && ex_ctrl_q[7] && ex_dest_q == rs)
                hazard = 1'b1;
            if (pend && pend_addr == rs)
                hazard = 1'b1;
        end
        if (use_rt && rt != '0) begin
            if (ex_valid_q && ex_ctrl_q[7] && ex_dest_q == rt)
                hazard = 1'b1;
            if (pend && pend_addr == rt)
                hazard = 1'b1;
        end
        if (ctrl[7] && pend)
            hazard = 1'b1;
    end

    assign ready  = !hazard && (!ex_valid_q || bus.ex_ready);
    assign accept = bus.if_valid && ready;
    assign leave  = ex_valid_q && bus.ex_ready;

    // Register file: cleared on reset, register 0 optionally hardwired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (wb_ok) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Output register: load on accept, drop to a bubble when drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_data1_q <= '0;
            ex_data2_q <= '0;
            ex_imm_q   <= '0;
            ex_dest_q  <= '0;
            ex_ctrl_q  <= '0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_data1_q <= data1;
            ex_data2_q <= data2;
            ex_imm_q   <= imm;
            ex_dest_q  <= dest;
            ex_ctrl_q  <= ctrl;
        end else if (leave) begin
            ex_valid_q <= 1'b0;
        end
    end

    // Single-entry load scoreboard; a leaving load beats any clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            pend_addr <= '0;
            pend_cnt  <= '0;
        end else if (leave && ex_ctrl_q[7] && ex_dest_q != '0) begin
            pend      <= 1'b1;
            pend_addr <= ex_dest_q;
            pend_cnt  <= 4'(LOAD_LAT);
        end else if (pend) begin
            pend_cnt <= pend_cnt - 4'd1;
            if (pend_cnt == 4'd1
                || (bus.wb_en && bus.wb_addr == pend_addr))
                pend <= 1'b0;
        end
    end

    assign bus.if_ready = ready;
    assign bus.ex_valid = ex_valid_q;
    assign bus.ex_data1 = ex_data1_q;
    assign bus.ex_data2 = ex_data2_q;
    assign bus.ex_imm   = ex_imm_q;
    assign bus.ex_dest  = ex_dest_q;
    assign bus.ex_ctrl  = ex_ctrl_q;
endmodule
